// File: rtl/enemy_sprite_renderer_if.sv
// Sprite ROM bus between the renderer (master) and the colour ROM (slave).
// The renderer supplies a column/row address and the ROM answers combinationally.
interface enemy_sprite_renderer_if;
  logic [9:0] SpriteX;
  logic [9:0] SpriteY;
  logic [7:0] SpriteR;
  logic [7:0] SpriteG;
  logic [7:0] SpriteB;

  modport master (output SpriteX, output SpriteY, input SpriteR, input SpriteG, input SpriteB);
  modport slave  (input SpriteX, input SpriteY, output SpriteR, output SpriteG, output SpriteB);
endinterface

// File: rtl/enemy_sprite_renderer.sv
// Enemy sprite renderer: during horizontal blank, fetch one sprite row from the ROM
// into a line buffer, then overlay it on the following scanline at the latched column.
module enemy_sprite_renderer #(
  parameter int SPRITE_W = 9,
  parameter int SPRITE_H = 7,
  parameter int V_TOTAL  = 525
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       line_start,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic       enemy_alive,
  enemy_sprite_renderer_if.master romBus,
  output logic [7:0] PixelR,
  output logic [7:0] PixelG,
  output logic [7:0] PixelB,
  output logic       pixel_on,
  output logic       busy
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, READY} stateT;

  stateT         state;
  stateT         nextState;
  logic [CW-1:0] fetchCnt;
  logic [9:0]    latchX;
  logic [9:0]    rowReg;
  logic          valid;
  logic [23:0]   lineBuf [0:(1<<CW)-1];

  logic [10:0]   nextY;
  logic [10:0]   rowFull;
  logic          startFetch;
  logic          lastFetch;
  logic [10:0]   hitOff;
  logic          hit;
  logic [23:0]   entry;
  logic          opaque;

  // Row selection for the scanline about to be drawn, wrapping at the frame end.
  always_comb begin
    nextY      = (DrawY == 10'(V_TOTAL - 1)) ? 11'd0 : ({1'b0, DrawY} + 11'd1);
    rowFull    = nextY - {1'b0, EnemyY};
    startFetch = enemy_alive && (nextY >= {1'b0, EnemyY}) && (rowFull < 11'(SPRITE_H));
    lastFetch  = (fetchCnt == CW'(SPRITE_W - 1));
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState      = state;
    busy           = 1'b0;
    romBus.SpriteX = '0;
    romBus.SpriteY = '0;
    if (line_start)                      nextState = startFetch ? FETCH : IDLE;
    else if (state == FETCH && lastFetch) nextState = READY;
    if (!Reset && state == FETCH) begin
      busy           = 1'b1;
      romBus.SpriteX = 10'(fetchCnt);
      romBus.SpriteY = rowReg;
    end
  end

  // A line_start always wins over fetch progress, so an in-flight fetch is simply restarted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetchCnt <= '0;
      latchX   <= '0;
      rowReg   <= '0;
      valid    <= 1'b0;
    end else if (line_start) begin
      latchX   <= EnemyX;
      valid    <= 1'b0;
      fetchCnt <= '0;
      if (startFetch) rowReg <= rowFull[9:0];
    end else if (state == FETCH) begin
      if (lastFetch) begin
        fetchCnt <= '0;
        valid    <= 1'b1;
      end else begin
        fetchCnt <= fetchCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && !line_start && state == FETCH)
      lineBuf[fetchCnt] <= {romBus.SpriteR, romBus.SpriteG, romBus.SpriteB};
  end

  // Hit window compared in 11 bits so a sprite near column 1023 never wraps to column 0.
  always_comb begin
    hitOff = {1'b0, DrawX} - {1'b0, latchX};
    hit    = valid && (DrawX >= latchX) && (hitOff < 11'(SPRITE_W));
    entry  = lineBuf[hitOff[CW-1:0]];
    opaque = hit && (entry != 24'h000000);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PixelR   <= '0;
      PixelG   <= '0;
      PixelB   <= '0;
      pixel_on <= 1'b0;
    end else begin
      PixelR   <= opaque ? entry[23:16] : 8'h00;
      PixelG   <= opaque ? entry[15:8]  : 8'h00;
      PixelB   <= opaque ? entry[7:0]   : 8'h00;
      pixel_on <= opaque;
    end
  end

endmodule

// File: tb/tb_enemy_sprite_renderer.sv
// Scoreboard bench for enemy_sprite_renderer: a frame-level model predicts each cycle's
// outputs into a queue, and an independent monitor compares them after every clock edge.
module tb_enemy_sprite_renderer;

  localparam int SW = 9;
  localparam int SH = 7;
  localparam int VT = 525;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       line_start = 1'b0;
  logic       enemy_alive = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [9:0] EnemyX = '0;
  logic [9:0] EnemyY = '0;
  logic [7:0] PixelR, PixelG, PixelB;
  logic       pixel_on, busy;
  logic [23:0] romWord;

  enemy_sprite_renderer_if romBus();

  always #5 Clk = ~Clk;

  // Behavioural sprite ROM; row 0 holds the reference colours used by the directed checks.
  function automatic logic [23:0] romPixel(input int x, input int y);
    logic [23:0] v;
    v = 24'h000000;
    if (y == 0) begin
      case (x)
        1: v = 24'h0050f8;
        2: v = 24'h0050f8;
        4: v = 24'hf8e800;
        5: v = 24'hf8e800;
        7: v = 24'h102030;
        default: v = 24'h000000;
      endcase
    end else if (((x + y) % 3) != 0) begin
      v = 24'((x * 131 + y * 977 + 17) * 40503) | 24'h000001;
    end
    return v;
  endfunction

  assign romWord        = romPixel(int'(romBus.SpriteX), int'(romBus.SpriteY));
  assign romBus.SpriteR = romWord[23:16];
  assign romBus.SpriteG = romWord[15:8];
  assign romBus.SpriteB = romWord[7:0];

  enemy_sprite_renderer #(.SPRITE_W(SW), .SPRITE_H(SH), .V_TOTAL(VT)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .line_start(line_start),
    .EnemyX(EnemyX), .EnemyY(EnemyY), .enemy_alive(enemy_alive), .romBus(romBus),
    .PixelR(PixelR), .PixelG(PixelG), .PixelB(PixelB), .pixel_on(pixel_on), .busy(busy)
  );

  typedef struct packed {
    logic        busy;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        on;
    logic [23:0] rgb;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  failures = 0;

  // Model: which sprite row is on display, where, and how far a pending fetch has got.
  int  mValid = 0;
  int  mLatchX = 0;
  int  mShownRow = 0;
  int  mFetching = 0;
  int  mK = 0;
  int  mFetchRow = 0;

  task automatic applyStimulus(input logic rst, input logic ls, input int dx, input int dy,
                               input int ex, input int ey, input logic alive);
    expT e;
    int  nextY;
    logic [23:0] c;
    @(negedge Clk);
    Reset = rst; line_start = ls; enemy_alive = alive;
    DrawX = 10'(dx); DrawY = 10'(dy); EnemyX = 10'(ex); EnemyY = 10'(ey);
    e = '0;
    if (!rst && mValid != 0 && dx >= mLatchX && dx <= mLatchX + SW - 1) begin
      c = romPixel(dx - mLatchX, mShownRow);
      e.on  = (c != 24'h000000);
      e.rgb = c;
    end
    if (rst) begin
      mValid = 0; mFetching = 0; mLatchX = 0;
    end else if (ls) begin
      nextY = (dy == VT - 1) ? 0 : dy + 1;
      mLatchX = ex;
      mValid = 0;
      if (alive && nextY >= ey && nextY <= ey + SH - 1) begin
        mFetching = 1; mK = 0; mFetchRow = nextY - ey;
      end else begin
        mFetching = 0;
      end
    end else if (mFetching != 0) begin
      mK++;
      if (mK == SW) begin
        mFetching = 0; mValid = 1; mShownRow = mFetchRow;
      end
    end
    e.busy = (mFetching != 0);
    e.sx   = (mFetching != 0) ? 10'(mK) : 10'd0;
    e.sy   = (mFetching != 0) ? 10'(mFetchRow) : 10'd0;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    checks++;
    if ({pixel_on, PixelR, PixelG, PixelB} !== {e.on, e.rgb}) begin
      failures++;
      $display("[TB] FAIL pixel t=%0t got on=%b rgb=%h want on=%b rgb=%h",
               $time, pixel_on, {PixelR, PixelG, PixelB}, e.on, e.rgb);
    end
    checks++;
    if (busy !== e.busy) begin
      failures++;
      $display("[TB] FAIL busy t=%0t got=%b want=%b", $time, busy, e.busy);
    end
    checks++;
    if ({romBus.SpriteX, romBus.SpriteY} !== {e.sx, e.sy}) begin
      failures++;
      $display("[TB] FAIL romAddr t=%0t got x=%0d y=%0d want x=%0d y=%0d",
               $time, romBus.SpriteX, romBus.SpriteY, e.sx, e.sy);
    end
  endtask

  initial begin
    expT e;
    forever begin
      @(posedge Clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idleSteps(input int n, input int dx, input int ex, input int ey);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, dx, 0, ex, ey, 1);
  endtask

  task automatic sweep(input int lo, input int hi, input int ex, input int ey);
    for (int x = lo; x <= hi; x++) applyStimulus(0, 0, x, 0, ex, ey, 1);
  endtask

  initial begin
    int ex, ey, dx, dy, r;
    logic rst, ls, alive;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    idleSteps(2, 0, 0, 0);

    // Basic fetch of row 0, then the reference pixels around column 200.
    applyStimulus(0, 1, 0, 99, 200, 100, 1);
    idleSteps(10, 0, 200, 100);
    applyStimulus(0, 0, 204, 100, 200, 100, 1);
    applyStimulus(0, 0, 201, 100, 200, 100, 1);
    applyStimulus(0, 0, 200, 100, 200, 100, 1);
    applyStimulus(0, 0, 209, 100, 200, 100, 1);
    sweep(198, 210, 200, 100);

    // Frame wrap: last scanline fetches row 0, NextY=7 is past the sprite.
    applyStimulus(0, 1, 0, VT - 1, 300, 0, 1);
    idleSteps(9, 0, 300, 0);
    sweep(298, 310, 300, 0);
    applyStimulus(0, 1, 0, 6, 300, 0, 1);
    idleSteps(3, 0, 300, 0);
    sweep(298, 310, 300, 0);

    // Abort in fetch cycle 4, restart on a different row.
    applyStimulus(0, 1, 0, 101, 400, 100, 1);
    idleSteps(4, 0, 400, 100);
    applyStimulus(0, 1, 0, 103, 400, 100, 1);
    idleSteps(9, 0, 400, 100);
    sweep(398, 410, 400, 100);

    // Reset in fetch cycle 3 leaves nothing visible.
    applyStimulus(0, 1, 0, 100, 400, 100, 1);
    idleSteps(3, 0, 400, 100);
    applyStimulus(1, 0, 0, 100, 400, 100, 1);
    sweep(395, 412, 400, 100);

    // Alive gating, then a mid-line EnemyX change that must not move the window.
    applyStimulus(0, 1, 0, 100, 500, 100, 0);
    idleSteps(10, 0, 500, 100);
    sweep(498, 510, 500, 100);
    applyStimulus(0, 1, 0, 102, 500, 100, 1);
    idleSteps(9, 0, 500, 100);
    sweep(496, 512, 600, 100);
    sweep(598, 610, 600, 100);

    // Right-edge window that would wrap past column 1023.
    applyStimulus(0, 1, 0, 100, 1020, 100, 1);
    idleSteps(9, 0, 1020, 100);
    sweep(1012, 1023, 1020, 100);
    sweep(0, 6, 1020, 100);

    // Randomised lines, positions, liveness and occasional resets.
    ex = 100; ey = 50; dy = 50;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      rst = (r == 0);
      ls = (r >= 1 && r <= 8);
      alive = ($urandom_range(0, 5) != 0);
      if (ls) begin
        dy = int'($urandom_range(0, VT - 1));
        ex = int'($urandom_range(0, 1023));
        ey = dy + int'($urandom_range(0, 10)) - 7;
        if (ey < 0) ey = 0;
        if (ey > 1023) ey = 1023;
      end else if ($urandom_range(0, 19) == 0) begin
        ex = int'($urandom_range(0, 1023));
      end
      dx = mLatchX + int'($urandom_range(0, 13)) - 2;
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = 1023;
      applyStimulus(rst, ls, dx, dy, ex, ey, alive);
    end

    @(posedge Clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got=%0d pending want=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_sprite_renderer.md
ENEMY_SPRITE_RENDERER -- requirements
Module: enemy_sprite_renderer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 9, sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 7, sprite height in pixels.
REQ-003 SHALL have parameter V_TOTAL, default 525, total scanlines per frame including blanking.
REQ-004 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port DrawX  input  10  current VGA pixel column.
REQ-007 SHALL have port DrawY  input  10  current VGA scanline.
REQ-008 SHALL have port line_start  input  1  one-cycle pulse at start of horizontal blank.
REQ-009 SHALL have port EnemyX  input  10  sprite top-left column.
REQ-010 SHALL have port EnemyY  input  10  sprite top-left row.
REQ-011 SHALL have port enemy_alive  input  1  sprite enabled.
REQ-012 SHALL have port SpriteX  output  10  column address to the sprite ROM.
REQ-013 SHALL have port SpriteY  output  10  row address to the sprite ROM.
REQ-014 SHALL have port SpriteR, SpriteG, SpriteB  input  8 each  combinational ROM colour data for the current SpriteX/SpriteY.
REQ-015 SHALL have port PixelR, PixelG, PixelB  output  8 each  registered pixel colour.
REQ-016 SHALL have port pixel_on  output  1  registered; high when Pixel* holds an opaque sprite pixel.
REQ-017 SHALL have port busy  output  1  high while the FSM is in FETCH.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH and READY.
REQ-019 SHALL, on line_start in any state, compute NextY = DrawY+1, or 0 when DrawY = V_TOTAL-1.
REQ-020 SHALL, on line_start, latch EnemyX into LatchX and compute row = NextY-EnemyY in 11-bit unsigned arithmetic without wrap.
REQ-021 SHALL, on line_start with enemy_alive=1 and EnemyY <= NextY <= EnemyY+SPRITE_H-1, clear line-buffer valid, set the fetch counter to 0, latch row and enter FETCH.
REQ-022 SHALL, on line_start when the REQ-021 condition is false, clear line-buffer valid and enter IDLE.
REQ-023 SHALL, in FETCH cycle k (k = 0..SPRITE_W-1), drive SpriteX=k and SpriteY=latched row.
REQ-024 SHALL, at the end of FETCH cycle k, write {SpriteR,SpriteG,SpriteB} into line-buffer entry k.
REQ-025 SHALL, after cycle SPRITE_W-1, set line-buffer valid and go to READY; fetch latency is exactly SPRITE_W cycles.
REQ-026 SHALL drive SpriteX=0 and SpriteY=0 in IDLE and READY.
REQ-027 SHALL treat line_start during FETCH as an abort and restart per REQ-019..REQ-022 in the same cycle; partially written entries are not displayed.
REQ-028 SHALL, each cycle, compute hit = valid AND LatchX <= DrawX <= LatchX+SPRITE_W-1 (11-bit compare, no wrap past column 1023).
REQ-029 SHALL, when hit, read entry e = DrawX-LatchX and register it to Pixel* one cycle later.
REQ-030 SHALL register pixel_on = hit AND entry != 24'h000000; 24'h000000 is transparent.
REQ-031 SHALL register Pixel*=0 and pixel_on=0 when hit is false or the entry is transparent.
REQ-032 SHALL use LatchX, not live EnemyX, for the hit test, so that mid-line EnemyX changes take effect at the next line_start.
REQ-033 SHALL keep the line buffer contents and valid unchanged in READY until the next line_start.

Reset
REQ-034 SHALL, with Reset high, force state IDLE, valid=0, fetch counter 0, LatchX=0 and row=0.
REQ-035 SHALL, with Reset high, force SpriteX=0, SpriteY=0, Pixel*=0, pixel_on=0 and busy=0.
REQ-036 SHALL give Reset priority over line_start; Reset asserted mid-FETCH abandons the fetch, and no pixel is shown until a later line_start completes a full fetch.

Verification
REQ-037 SHALL verify basic fetch: EnemyX=200, EnemyY=100, alive=1, line_start with DrawY=99 -> busy high 9 cycles, SpriteY=0, SpriteX steps 0..8, then busy low.
REQ-038 SHALL verify row-0 pixels after REQ-037: DrawX=204 -> next cycle Pixel=f8/e8/00, pixel_on=1; DrawX=201 -> 00/50/f8, pixel_on=1; DrawX=200 -> pixel_on=0, Pixel=0; DrawX=209 -> pixel_on=0.
REQ-039 SHALL verify frame wrap: EnemyY=0, line_start with DrawY=524 -> fetch row 0; EnemyY=0, line_start with DrawY=6 (NextY=7) -> IDLE, no fetch.
REQ-040 SHALL verify abort: second line_start in FETCH cycle 4 -> SpriteX returns to 0 the next cycle; the full 9-cycle fetch completes and only the new row is displayed.
REQ-041 SHALL verify reset mid-fetch: Reset at FETCH cycle 3 -> busy=0, pixel_on=0 for every DrawX until the next completed fetch.
REQ-042 SHALL verify alive gating and position latch: alive=0 at line_start -> no fetch, pixel_on=0; EnemyX changed mid-line after a fetch -> hit window stays at the old LatchX.
